// File: rtl/ex_pkg.sv
// ============================================================================
// Module : ex_pkg
// Desc   : Shared encodings for the execute stage (ALU ctrl, M-ext ops, FSM).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ex_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_EQU   = 5'd2,
    ALU_NEQ   = 5'd3,
    ALU_SLT   = 5'd4,
    ALU_SGE   = 5'd5,
    ALU_SLTU  = 5'd6,
    ALU_SGEU  = 5'd7,
    ALU_XOR   = 5'd8,
    ALU_OR    = 5'd9,
    ALU_SLL   = 5'd10,
    ALU_SRL   = 5'd11,
    ALU_SRA   = 5'd12,
    ALU_AND   = 5'd13,
    ALU_NO_OP = 5'd14
  } alu_ctrl_e;

  // Matches RV32M funct3, so bit 2 selects divide and bit 1 selects remainder.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ex_md_iter.sv
// ============================================================================
// Module : ex_md_iter
// Desc   : Iterative RV32M datapath: shift-add multiply, restoring divide.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_md_iter
  import ex_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_fast,
  output logic [XLEN-1:0] o_fast_res,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0]  C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(XLEN - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_m;
  logic              r_neg;
  logic              r_neg_r;

  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div0, w_ovf;
  logic [XLEN:0]     w_sum, w_shift, w_diff;
  logic              w_qbit;
  logic [XLEN-1:0]   w_nhi, w_nlo;
  logic [2*XLEN-1:0] w_prod;

  always_comb begin
    w_a_sgn = (i_op != MD_MULHU) && (i_op != MD_DIVU) && (i_op != MD_REMU);
    w_b_sgn = w_a_sgn && (i_op != MD_MULHSU);
    w_a_neg = w_a_sgn && i_a[XLEN-1];
    w_b_neg = w_b_sgn && i_b[XLEN-1];
    w_a_mag = w_a_neg ? -i_a : i_a;
    w_b_mag = w_b_neg ? -i_b : i_b;

    w_div0 = i_op[2] && (i_b == '0);
    w_ovf  = ((i_op == MD_DIV) || (i_op == MD_REM)) && (i_a == C_INT_MIN) && (i_b == '1);
    o_fast = w_div0 || w_ovf;
    if (w_div0) o_fast_res = i_op[1] ? i_a : '1;
    else        o_fast_res = i_op[1] ? '0 : i_a;
  end

  // One iteration: multiply adds into the high half then shifts right,
  // divide shifts the dividend into the partial remainder and trial-subtracts.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_m};
    w_qbit  = ~w_diff[XLEN];
    if (r_op[2]) begin
      w_nhi = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], w_qbit};
    end else begin
      w_nhi = w_sum[XLEN:1];
      w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
    end

    w_prod = {w_nhi, w_nlo};
    if (r_neg) w_prod = -w_prod;
    if (!r_op[2])     o_result = (r_op == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else if (!r_op[1]) o_result = r_neg   ? -w_nlo : w_nlo;
    else               o_result = r_neg_r ? -w_nhi : w_nhi;
  end

  assign o_busy = (r_state == S_CALC);
  assign o_done = o_busy && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_m     <= '0;
      r_neg   <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_CALC;
            r_cnt   <= '0;
            r_op    <= i_op;
            r_hi    <= '0;
            r_lo    <= i_op[2] ? w_a_mag : w_b_mag;
            r_m     <= i_op[2] ? w_b_mag : w_a_mag;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
          end
        end
        S_CALC: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage_md.sv
// ============================================================================
// Module : ex_stage_md
// Desc   : Execute stage: single-cycle ALU plus iterative M-unit, valid/ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      alu_ctrl_i,
  input  logic            md_en_i,
  input  logic [2:0]      md_op_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            reg_we_i,
  input  logic            btype_flag_i,
  input  logic [XLEN-1:0] btype_jump_pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] op_c_o,
  output logic [4:0]      reg_waddr_o,
  output logic            reg_we_o,
  output logic            branch_flag_o,
  output logic [XLEN-1:0] branch_pc_o,
  output logic            busy_o
);

  logic [CNT_W-1:0] w_sh;
  logic             w_lts, w_ltu;
  logic [XLEN-1:0]  w_alu;
  logic             w_accept, w_start, w_load_now;
  logic             w_fast, w_done;
  logic [XLEN-1:0]  w_fast_res, w_md_res;

  logic [4:0]       r_pend_waddr;
  logic             r_pend_we;
  logic [XLEN-1:0]  r_pend_pc;

  always_comb begin
    w_sh  = op_b_i[CNT_W-1:0];
    w_lts = $signed(op_a_i) < $signed(op_b_i);
    w_ltu = op_a_i < op_b_i;
    case (alu_ctrl_i)
      ALU_ADD:  w_alu = op_a_i + op_b_i;
      ALU_SUB:  w_alu = op_a_i - op_b_i;
      ALU_EQU:  w_alu = XLEN'(op_a_i == op_b_i);
      ALU_NEQ:  w_alu = XLEN'(op_a_i != op_b_i);
      ALU_SLT:  w_alu = XLEN'(w_lts);
      ALU_SGE:  w_alu = XLEN'(!w_lts);
      ALU_SLTU: w_alu = XLEN'(w_ltu);
      ALU_SGEU: w_alu = XLEN'(!w_ltu);
      ALU_XOR:  w_alu = op_a_i ^ op_b_i;
      ALU_OR:   w_alu = op_a_i | op_b_i;
      ALU_SLL:  w_alu = op_a_i << w_sh;
      ALU_SRL:  w_alu = op_a_i >> w_sh;
      ALU_SRA:  w_alu = $unsigned($signed(op_a_i) >>> w_sh);
      ALU_AND:  w_alu = op_a_i & op_b_i;
      default:  w_alu = '0;
    endcase
  end

  assign in_ready_o = rst_n && !busy_o && (!out_valid_o || out_ready_i) && !flush_i;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_start    = w_accept && md_en_i && !w_fast;
  assign w_load_now = w_accept && (!md_en_i || w_fast);

  ex_md_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_md (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_flush    (flush_i),
    .i_op       (md_op_i),
    .i_a        (op_a_i),
    .i_b        (op_b_i),
    .o_fast     (w_fast),
    .o_fast_res (w_fast_res),
    .o_busy     (busy_o),
    .o_done     (w_done),
    .o_result   (w_md_res)
  );

  // Accepting requires a drain slot, so a load never overwrites pending data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_o   <= 1'b0;
      op_c_o        <= '0;
      reg_waddr_o   <= '0;
      reg_we_o      <= 1'b0;
      branch_flag_o <= 1'b0;
      branch_pc_o   <= '0;
      r_pend_waddr  <= '0;
      r_pend_we     <= 1'b0;
      r_pend_pc     <= '0;
    end else begin
      if (w_start) begin
        r_pend_waddr <= reg_waddr_i;
        r_pend_we    <= reg_we_i;
        r_pend_pc    <= btype_jump_pc_i;
      end
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (w_load_now) begin
        out_valid_o   <= 1'b1;
        op_c_o        <= md_en_i ? w_fast_res : w_alu;
        reg_waddr_o   <= reg_waddr_i;
        reg_we_o      <= reg_we_i;
        branch_flag_o <= !md_en_i && btype_flag_i && (w_alu != '0);
        branch_pc_o   <= btype_jump_pc_i;
      end else if (w_done) begin
        out_valid_o   <= 1'b1;
        op_c_o        <= w_md_res;
        reg_waddr_o   <= r_pend_waddr;
        reg_we_o      <= r_pend_we;
        branch_flag_o <= 1'b0;
        branch_pc_o   <= r_pend_pc;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_md.sv
// ============================================================================
// Module : tb_ex_stage_md
// Desc   : Directed self-checking bench for ex_stage_md (XLEN = 32).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage_md;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  alu_ctrl = '0;
  logic        md_en = 1'b0;
  logic [2:0]  md_op = '0;
  logic [4:0]  reg_waddr = '0;
  logic        reg_we = 1'b0;
  logic        btype_flag = 1'b0;
  logic [31:0] btype_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] op_c;
  logic [4:0]  waddr_o;
  logic        we_o;
  logic        bflag_o;
  logic [31:0] bpc_o;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage_md #(.XLEN(32), .CNT_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .op_a_i          (op_a),
    .op_b_i          (op_b),
    .alu_ctrl_i      (alu_ctrl),
    .md_en_i         (md_en),
    .md_op_i         (md_op),
    .reg_waddr_i     (reg_waddr),
    .reg_we_i        (reg_we),
    .btype_flag_i    (btype_flag),
    .btype_jump_pc_i (btype_pc),
    .flush_i         (flush),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .op_c_o          (op_c),
    .reg_waddr_o     (waddr_o),
    .reg_we_o        (we_o),
    .branch_flag_o   (bflag_o),
    .branch_pc_o     (bpc_o),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one M op, then counts cycles until out_valid (accept cycle = 1).
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bc, output logic [31:0] res);
    in_valid = 1'b1; md_en = 1'b1; md_op = op; op_a = a; op_b = b;
    reg_waddr = 5'd9; reg_we = 1'b1; btype_flag = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1; bc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      tick();
      lat++;
    end
    res = op_c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if ({out_valid, op_c, waddr_o, we_o, bflag_o, bpc_o, busy, in_ready} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, op_c, waddr_o, we_o, bflag_o, bpc_o, busy, in_ready});
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_alu();
    logic [4:0]  v_ctrl [6] = '{ALU_SRA, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_XOR, ALU_NO_OP};
    logic [31:0] v_a    [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0000_F0F0, 32'd5};
    logic [31:0] v_b    [6] = '{32'd4, 32'd1, 32'd1, 32'd35, 32'h0000_FF00, 32'd6};
    logic [31:0] v_exp  [6] = '{32'hF800_0000, 32'd1, 32'd0, 32'd8, 32'h0000_0FF0, 32'd0};
    md_en = 1'b0; in_valid = 1'b1; reg_we = 1'b1; reg_waddr = 5'd3;
    alu_ctrl = ALU_SUB; op_a = 32'd5; op_b = 32'd7;
    tick();
    n_tests++;
    if ({out_valid, op_c, waddr_o, we_o} !== {1'b1, 32'hFFFF_FFFE, 5'd3, 1'b1}) begin
      n_fail++; $display("FAIL alu_sub: got v=%b c=%h a=%0d we=%b want v=1 c=fffffffe a=3 we=1", out_valid, op_c, waddr_o, we_o);
    end
    alu_ctrl = ALU_EQU; op_a = 32'd3; op_b = 32'd3; btype_flag = 1'b1; btype_pc = 32'h0000_1234;
    tick();
    n_tests++;
    if ({op_c, bflag_o, bpc_o} !== {32'd1, 1'b1, 32'h0000_1234}) begin
      n_fail++; $display("FAIL alu_equ_branch: got c=%h bf=%b pc=%h want c=1 bf=1 pc=1234", op_c, bflag_o, bpc_o);
    end
    for (int i = 0; i < 6; i++) begin
      alu_ctrl = v_ctrl[i]; op_a = v_a[i]; op_b = v_b[i];
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      n_tests++;
      if ({out_valid, op_c, bflag_o} !== {1'b1, v_exp[i], v_exp[i] != 32'd0}) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got v=%b c=%h bf=%b want c=%h", i, out_valid, op_c, bflag_o, v_exp[i]);
      end
    end
    in_valid = 1'b0; btype_flag = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_mul();
    int lat, bc;
    logic [31:0] res;
    run_md(MD_MULH, 32'h8000_0000, 32'h8000_0000, lat, bc, res);
    n_tests++;
    if ({res, waddr_o, bflag_o} !== {32'h4000_0000, 5'd9, 1'b0}) begin
      n_fail++; $display("FAIL mulh_res: got %h a=%0d bf=%b want 40000000 a=9 bf=0", res, waddr_o, bflag_o);
    end
    n_tests++;
    if (lat !== 33 || bc !== 32) begin n_fail++; $display("FAIL mulh_timing: got lat=%0d busy=%0d want 33 32", lat, bc); end
    run_md(MD_MULHSU, 32'hFFFF_FFFF, 32'd2, lat, bc, res);
    n_tests++;
    if (res !== 32'hFFFF_FFFF || lat !== 33) begin n_fail++; $display("FAIL mulhsu: got %h lat=%0d want ffffffff 33", res, lat); end
    run_md(MD_MUL, 32'hFFFF_FFFD, 32'd5, lat, bc, res);
    n_tests++;
    if (res !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mul_neg: got %h want fffffff1", res); end
    run_md(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, res);
    n_tests++;
    if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu: got %h want fffffffe", res); end
  endtask

  task automatic test_div();
    int lat, bc;
    logic [31:0] res;
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, res);
    n_tests++;
    if (res !== 32'hFFFF_FFFD || lat !== 33) begin n_fail++; $display("FAIL div_neg: got %h lat=%0d want fffffffd 33", res, lat); end
    run_md(MD_REM, 32'hFFFF_FFF9, 32'd2, lat, bc, res);
    n_tests++;
    if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg: got %h want ffffffff", res); end
    run_md(MD_REMU, 32'd100, 32'd7, lat, bc, res);
    n_tests++;
    if (res !== 32'd2) begin n_fail++; $display("FAIL remu: got %h want 2", res); end
  endtask

  task automatic test_fast();
    int lat, bc;
    logic [31:0] res;
    run_md(MD_DIVU, 32'd7, 32'd0, lat, bc, res);
    n_tests++;
    if (res !== 32'hFFFF_FFFF || lat !== 1 || bc !== 0) begin
      n_fail++; $display("FAIL divu_zero: got %h lat=%0d busy=%0d want ffffffff 1 0", res, lat, bc);
    end
    run_md(MD_REM, 32'd7, 32'd0, lat, bc, res);
    n_tests++;
    if (res !== 32'd7 || lat !== 1) begin n_fail++; $display("FAIL rem_zero: got %h lat=%0d want 7 1", res, lat); end
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, res);
    n_tests++;
    if (res !== 32'h8000_0000 || lat !== 1) begin n_fail++; $display("FAIL div_ovf: got %h lat=%0d want 80000000 1", res, lat); end
    run_md(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, res);
    n_tests++;
    if (res !== 32'd0 || lat !== 1) begin n_fail++; $display("FAIL rem_ovf: got %h lat=%0d want 0 1", res, lat); end
  endtask

  task automatic test_stall();
    int n;
    in_valid = 1'b1; md_en = 1'b1; md_op = MD_MUL; op_a = 32'd3; op_b = 32'd5; reg_waddr = 5'd9;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    in_valid = 1'b1; md_en = 1'b0; alu_ctrl = ALU_ADD; op_a = 32'd1; op_b = 32'd2; reg_waddr = 5'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({out_valid, op_c, in_ready} !== {1'b1, 32'd15, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b c=%h rdy=%b want v=1 c=f rdy=0", i, out_valid, op_c, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, op_c, waddr_o} !== {1'b1, 32'd3, 5'd4}) begin
      n_fail++; $display("FAIL stall_next_alu: got v=%b c=%h a=%0d want v=1 c=3 a=4", out_valid, op_c, waddr_o);
    end
    tick();
  endtask

  task automatic test_flush();
    int lat, bc;
    logic [31:0] res;
    in_valid = 1'b1; md_en = 1'b1; md_op = MD_DIVU; op_a = 32'd1000; op_b = 32'd3;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_state: got busy=%b v=%b want 0 0", busy, out_valid); end
    run_md(MD_DIVU, 32'd100, 32'd7, lat, bc, res);
    n_tests++;
    if (res !== 32'd14 || lat !== 33) begin n_fail++; $display("FAIL flush_next_divu: got %h lat=%0d want e 33", res, lat); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic [31:0] res;
    tick();
    in_valid = 1'b1; md_en = 1'b1; md_op = MD_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({out_valid, op_c, waddr_o, we_o, bflag_o, bpc_o, busy, in_ready} !== 74'd0) begin
      n_fail++; $display("FAIL reset_mid: got %h want 0", {out_valid, op_c, waddr_o, we_o, bflag_o, bpc_o, busy, in_ready});
    end
    rst_n = 1'b1;
    run_md(MD_MUL, 32'd6, 32'd7, lat, bc, res);
    n_tests++;
    if (res !== 32'd42 || lat !== 33) begin n_fail++; $display("FAIL reset_mid_mul: got %0d lat=%0d want 42 33", res, lat); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_fast();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
